// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the operands and start; the slave returns status and result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  ready, busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output ready, busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin through one full-subtractor
// cell and a borrow flop, WIDTH bit-cycles per operation.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             bout_q;
  logic             done_q;

  logic             d_d;
  logic             br_d;
  logic [WIDTH-1:0] res_d;

  // Full-subtractor cell on the current LSBs; the new bit enters the result MSB.
  always_comb begin
    d_d  = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    br_d = (~a_sh_q[0] & b_sh_q[0]) | (~a_sh_q[0] & br_q) | (b_sh_q[0] & br_q);
    res_d = res_q >> 1;
    res_d[WIDTH-1] = d_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          res_q  <= res_d;
          br_q   <= br_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // Published only here, so diff/bout stay stable through a following RUN.
            state_q <= DONE;
            diff_q  <= res_d;
            bout_q  <= br_d;
            done_q  <= 1'b1;
          end
        end
        default: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= RUN;
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            br_q    <= bus.bin;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.ready = (state_q == IDLE) || (state_q == DONE);
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor at WIDTH 8, 4 and 1,
// checked against an integer-arithmetic reference of a - b - bin.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();
  serial_subtractor_if #(.WIDTH(1)) bus1 ();

  serial_subtractor #(.WIDTH(8)) u_w8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_subtractor #(.WIDTH(4)) u_w4 (.clk(clk), .rst(rst), .bus(bus4));
  serial_subtractor #(.WIDTH(1)) u_w1 (.clk(clk), .rst(rst), .bus(bus1));

  // Reference: {bout, diff} with diff zero-extended into bits [7:0].
  function automatic logic [8:0] ref_sub(input int w, input logic [7:0] a, b, input logic bin);
    int mask, r;
    logic [8:0] res;
    mask = (1 << w) - 1;
    r = (int'(a) & mask) - (int'(b) & mask) - int'(bin);
    res[8] = (r < 0);
    res[7:0] = 8'((r + (1 << w)) & mask);
    return res;
  endfunction

  task automatic drive(input int w, input logic s, input logic [7:0] a, b, input logic bin);
    case (w)
      8: begin bus8.start = s; bus8.a = a; bus8.b = b; bus8.bin = bin; end
      4: begin bus4.start = s; bus4.a = a[3:0]; bus4.b = b[3:0]; bus4.bin = bin; end
      default: begin bus1.start = s; bus1.a = a[0]; bus1.b = b[0]; bus1.bin = bin; end
    endcase
  endtask

  function automatic logic done_of(input int w);
    case (w)
      8: return bus8.done;
      4: return bus4.done;
      default: return bus1.done;
    endcase
  endfunction

  function automatic logic [8:0] res_of(input int w);
    case (w)
      8: return {bus8.bout, bus8.diff};
      4: return {bus4.bout, 4'b0, bus4.diff};
      default: return {bus1.bout, 7'b0, bus1.diff};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call #1 after an edge with the DUT ready; returns in the done cycle.
  task automatic op(input int w, input logic [7:0] a, b, input logic bin,
                    output logic [8:0] got, output int lat);
    drive(w, 1'b1, a, b, bin);
    tick();
    drive(w, 1'b0, a, b, bin);
    lat = 0;
    while (!done_of(w) && lat < 40) begin
      tick();
      lat++;
    end
    got = res_of(w);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(8, 1'b1, 8'hFF, 8'h01, 1'b1);
    drive(4, 1'b0, 8'h0, 8'h0, 1'b0);
    drive(1, 1'b0, 8'h0, 8'h0, 1'b0);
    tick();
    tick();
    tests++;
    if ({bus8.ready, bus8.busy, bus8.done, bus8.diff, bus8.bout} !== {3'b100, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset_state got rdy=%b busy=%b done=%b diff=%h bout=%b exp rdy=1 busy=0 done=0 diff=00 bout=0",
               bus8.ready, bus8.busy, bus8.done, bus8.diff, bus8.bout);
    end
    drive(8, 1'b0, 8'h0, 8'h0, 1'b0);
    rst = 1'b0;
    tick();
    tests++;
    if ({bus8.ready, bus8.busy, bus8.done} !== 3'b100) begin
      fails++;
      $display("FAIL idle_after_reset got rdy/busy/done=%b exp 100", {bus8.ready, bus8.busy, bus8.done});
    end
  endtask

  task automatic test_directed();
    logic [8:0] got;
    int lat;
    logic [7:0] va [3] = '{8'h5A, 8'h00, 8'h10};
    logic [7:0] vb [3] = '{8'h3C, 8'h01, 8'h0F};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] ve [3] = '{9'h01E, 9'h1FF, 9'h000};
    for (int i = 0; i < 3; i++) begin
      op(8, va[i], vb[i], vc[i], got, lat);
      tests++;
      if (got !== ve[i] || lat != 8) begin
        fails++;
        $display("FAIL directed_%0d got {bout,diff}=%h lat=%0d exp %h lat=8", i, got, lat, ve[i]);
      end
      tests++;
      if (bus8.ready !== 1'b1 || bus8.busy !== 1'b0) begin
        fails++;
        $display("FAIL done_status_%0d got rdy=%b busy=%b exp rdy=1 busy=0", i, bus8.ready, bus8.busy);
      end
      tick();
    end
  endtask

  task automatic test_start_held();
    logic [7:0] a0, b0;
    logic bin0;
    int ndone;
    logic [8:0] got;
    a0 = 8'($urandom); b0 = 8'($urandom); bin0 = 1'($urandom);
    drive(8, 1'b1, a0, b0, bin0);
    repeat (8) begin
      tick();
      drive(8, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    ndone = 0;
    got = '0;
    repeat (20) begin
      if (bus8.done) begin
        ndone++;
        got = res_of(8);
      end
      tick();
    end
    tests++;
    if (ndone != 1 || got !== ref_sub(8, a0, b0, bin0)) begin
      fails++;
      $display("FAIL start_held got dones=%0d res=%h exp dones=1 res=%h", ndone, got, ref_sub(8, a0, b0, bin0));
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] got;
    int lat;
    logic [7:0] prev;
    logic held_ok;
    op(8, 8'h5A, 8'h3C, 1'b0, got, lat);
    tests++;
    if (got !== 9'h01E || lat != 8) begin
      fails++;
      $display("FAIL b2b_first got %h lat=%0d exp 01e lat=8", got, lat);
    end
    prev = bus8.diff;
    drive(8, 1'b1, 8'h80, 8'h01, 1'b0);
    tick();
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    tests++;
    if (bus8.busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_no_idle got busy=%b exp 1", bus8.busy);
    end
    lat = 0;
    held_ok = 1'b1;
    while (!bus8.done && lat < 40) begin
      if (bus8.diff !== prev) held_ok = 1'b0;
      tick();
      lat++;
    end
    tests++;
    if (!held_ok) begin
      fails++;
      $display("FAIL b2b_diff_held got changed exp %h stable", prev);
    end
    tests++;
    if (res_of(8) !== 9'h07F || lat != 8) begin
      fails++;
      $display("FAIL b2b_second got %h lat=%0d exp 07f lat=8", res_of(8), lat);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic [8:0] got;
    int lat, ndone;
    drive(8, 1'b1, 8'hC3, 8'h5A, 1'b1);
    tick();
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({bus8.ready, bus8.busy, bus8.done, bus8.diff, bus8.bout} !== {3'b100, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL mid_run_reset got rdy=%b busy=%b done=%b diff=%h bout=%b exp 1 0 0 00 0",
               bus8.ready, bus8.busy, bus8.done, bus8.diff, bus8.bout);
    end
    ndone = 0;
    repeat (12) begin
      if (bus8.done) ndone++;
      tick();
    end
    tests++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL aborted_no_done got %0d pulses exp 0", ndone);
    end
    op(8, 8'h34, 8'h12, 1'b1, got, lat);
    tests++;
    if (got !== ref_sub(8, 8'h34, 8'h12, 1'b1) || lat != 8) begin
      fails++;
      $display("FAIL after_abort got %h lat=%0d exp %h lat=8", got, lat, ref_sub(8, 8'h34, 8'h12, 1'b1));
    end
    tick();
  endtask

  task automatic test_exhaustive();
    logic [8:0] got;
    int lat;
    int wl [2] = '{4, 1};
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < (1 << wl[k]); a++)
        for (int b = 0; b < (1 << wl[k]); b++)
          for (int c = 0; c < 2; c++) begin
            op(wl[k], 8'(a), 8'(b), 1'(c), got, lat);
            tests++;
            if (got !== ref_sub(wl[k], 8'(a), 8'(b), 1'(c)) || lat != wl[k]) begin
              fails++;
              $display("FAIL exh_w%0d a=%0d b=%0d bin=%0d got %h lat=%0d exp %h lat=%0d",
                       wl[k], a, b, c, got, lat, ref_sub(wl[k], 8'(a), 8'(b), 1'(c)), wl[k]);
            end
          end
      tick();
    end
  endtask

  task automatic test_random();
    logic [8:0] got;
    int lat;
    logic [7:0] a, b;
    logic c;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      if ($urandom_range(1, 0) == 1) tick();
      op(8, a, b, c, got, lat);
      tests++;
      if (got !== ref_sub(8, a, b, c) || lat != 8) begin
        fails++;
        $display("FAIL rand_%0d a=%h b=%h bin=%b got %h lat=%0d exp %h lat=8", i, a, b, c, got, lat, ref_sub(8, a, b, c));
      end
    end
    tick();
  endtask

  initial begin
    drive(8, 1'b0, 8'h0, 8'h0, 1'b0);
    drive(4, 1'b0, 8'h0, 8'h0, 1'b0);
    drive(1, 1'b0, 8'h0, 8'h0, 1'b0);
    test_reset();
    test_directed();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
